// File: rtl/baudgen_os.sv
// Fractional-N oversampling baud generator: produces oversample, mid-bit and
// end-of-bit ticks from a runtime-loadable integer + fractional divisor.
module baudgen_os #(
   parameter int unsigned DIV_W    = 16,
   parameter int unsigned FRAC_W   = 4,
   parameter int unsigned OS       = 16,
   parameter int unsigned DEF_INT  = 54,
   parameter int unsigned DEF_FRAC = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clk_ena,
   input  logic                  restart,
   input  logic [DIV_W-1:0]      div_int,
   input  logic [FRAC_W-1:0]     div_frac,
   input  logic                  div_load,
   output logic                  os_tick,
   output logic                  sample_tick,
   output logic                  bit_tick,
   output logic [$clog2(OS)-1:0] os_phase
);
   localparam int unsigned      PH_W    = $clog2(OS);
   localparam logic [DIV_W:0]   CNT_ONE = (DIV_W+1)'(1);
   localparam logic [DIV_W-1:0] MIN_INT = DIV_W'(2);
   localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
   localparam logic [PH_W-1:0]  PH_MID  = PH_W'(OS/2);

   logic [DIV_W:0]    cnt_q, cnt_d, per_len;
   logic [FRAC_W-1:0] facc_q, facc_d, fsum;
   logic              carry;
   logic [PH_W-1:0]   phase_q, phase_d, phase_inc;
   logic              os_q, os_d, smp_q, smp_d, bit_q, bit_d;
   logic [DIV_W-1:0]  a_int_q, a_int_d, p_int_q, p_int_d, src_int;
   logic [FRAC_W-1:0] a_frac_q, a_frac_d, p_frac_q, p_frac_d, src_frac;
   logic              pend_q, pend_d, term, apply;

   always_comb begin
      // Period length stretches by one cycle whenever the fractional accumulator overflows
      {carry, fsum} = {1'b0, facc_q} + {1'b0, a_frac_q};
      per_len       = {1'b0, a_int_q} + {{DIV_W{1'b0}}, carry};
      term          = (cnt_q == per_len - CNT_ONE);
      phase_inc     = phase_q + PH_ONE;

      // A load coinciding with an apply event goes straight to the active pair
      src_int  = div_load ? div_int  : p_int_q;
      src_frac = div_load ? div_frac : p_frac_q;
      apply    = (div_load | pend_q) & (~clk_ena | restart | term);
      p_int_d  = src_int;
      p_frac_d = src_frac;
      pend_d   = div_load | pend_q;
      a_int_d  = a_int_q;
      a_frac_d = a_frac_q;
      if (apply) begin
         a_int_d  = (src_int < MIN_INT) ? MIN_INT : src_int;
         a_frac_d = src_frac;
         pend_d   = 1'b0;
      end

      cnt_d   = cnt_q + CNT_ONE;
      facc_d  = facc_q;
      phase_d = phase_q;
      os_d    = 1'b0;
      smp_d   = 1'b0;
      bit_d   = 1'b0;
      if (!clk_ena || restart) begin
         cnt_d   = '0;
         facc_d  = '0;
         phase_d = '0;
      end else if (term) begin
         cnt_d   = '0;
         facc_d  = fsum;
         phase_d = phase_inc;
         os_d    = 1'b1;
         smp_d   = (phase_inc == PH_MID);
         bit_d   = (phase_inc == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         facc_q   <= '0;
         phase_q  <= '0;
         os_q     <= 1'b0;
         smp_q    <= 1'b0;
         bit_q    <= 1'b0;
         a_int_q  <= DIV_W'(DEF_INT);
         a_frac_q <= FRAC_W'(DEF_FRAC);
         p_int_q  <= DIV_W'(DEF_INT);
         p_frac_q <= FRAC_W'(DEF_FRAC);
         pend_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         facc_q   <= facc_d;
         phase_q  <= phase_d;
         os_q     <= os_d;
         smp_q    <= smp_d;
         bit_q    <= bit_d;
         a_int_q  <= a_int_d;
         a_frac_q <= a_frac_d;
         p_int_q  <= p_int_d;
         p_frac_q <= p_frac_d;
         pend_q   <= pend_d;
      end
   end

   assign os_tick     = os_q;
   assign sample_tick = smp_q;
   assign bit_tick    = bit_q;
   assign os_phase    = phase_q;

endmodule

// File: tb/tb_baudgen_os.sv
// Directed bench for baudgen_os: cycle-level reference model compared every
// cycle, plus hand-computed period/phase expectations.
module tb_baudgen_os;
   localparam int DIV_W  = 16;
   localparam int FRAC_W = 4;
   localparam int OS     = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clk_ena = 1'b0;
   logic              restart = 1'b0;
   logic              div_load = 1'b0;
   logic [DIV_W-1:0]  div_int = '0;
   logic [FRAC_W-1:0] div_frac = '0;
   logic              os_tick, sample_tick, bit_tick;
   logic [$clog2(OS)-1:0] os_phase;

   int passed = 0;
   int total  = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   baudgen_os #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OS(OS), .DEF_INT(54), .DEF_FRAC(4)) dut (
      .clk(clk), .rst_n(rst_n), .clk_ena(clk_ena), .restart(restart),
      .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
      .os_tick(os_tick), .sample_tick(sample_tick), .bit_tick(bit_tick),
      .os_phase(os_phase)
   );

   // Reference: cycles elapsed in the current oversample period, fractional
   // remainder as plain integers, and the period index within the bit.
   int m_int = 54, m_frac = 4, p_int = 54, p_frac = 4, m_pend = 0;
   int m_acc = 0, m_el = 0, m_ph = 0;
   int e_os = 0, e_smp = 0, e_bit = 0;

   always @(posedge clk or negedge rst_n) begin
      int len, nacc;
      bit done;
      if (!rst_n) begin
         m_int = 54; m_frac = 4; p_int = 54; p_frac = 4; m_pend = 0;
         m_acc = 0; m_el = 0; m_ph = 0; e_os = 0; e_smp = 0; e_bit = 0;
      end else begin
         if (div_load) begin
            p_int = int'(div_int); p_frac = int'(div_frac); m_pend = 1;
         end
         len  = m_int + (m_acc + m_frac) / (1 << FRAC_W);
         nacc = (m_acc + m_frac) % (1 << FRAC_W);
         done = clk_ena && !restart && (m_el + 1 == len);
         if (m_pend != 0 && (!clk_ena || restart || done)) begin
            m_int = (p_int < 2) ? 2 : p_int; m_frac = p_frac; m_pend = 0;
         end
         e_os = 0; e_smp = 0; e_bit = 0;
         if (!clk_ena || restart) begin
            m_el = 0; m_acc = 0; m_ph = 0;
         end else if (done) begin
            m_el = 0; m_acc = nacc; m_ph = (m_ph + 1) % OS;
            e_os = 1; e_smp = (m_ph == OS/2); e_bit = (m_ph == 0);
         end else begin
            m_el++;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if (os_tick === e_os[0] && sample_tick === e_smp[0] && bit_tick === e_bit[0]
             && os_phase === 4'(m_ph))
            passed++;
         else
            $display("FAIL model t=%0t: os/smp/bit/phase got %b%b%b/%0d, expected %0d%0d%0d/%0d",
                     $time, os_tick, sample_tick, bit_tick, os_phase, e_os, e_smp, e_bit, m_ph);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic wait_tick(input int maxc, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (os_tick !== 1'b1 && n < maxc);
      if (os_tick !== 1'b1) begin
         total++;
         $display("FAIL tick_timeout: no os_tick within %0d cycles", maxc);
      end
   endtask

   task automatic load(input int di, input int df);
      div_int = DIV_W'(di); div_frac = FRAC_W'(df); div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, acc, nbit, nsmp;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("reset_phase", int'(os_phase), 0);
      check("reset_os_tick", int'(os_tick), 0);
      rst_n = 1'b1; clk_ena = 1'b1;

      // default divisor 54 + 4/16
      acc = 0;
      for (int k = 1; k <= 32; k++) begin
         wait_tick(100, n);
         acc += n;
         if (k <= 4) check($sformatf("def_period%0d", k), n, (k == 4) ? 55 : 54);
         if (k == 8) check("def_sample_at_8", int'(sample_tick), 1);
         if (k == 16) begin
            check("def_bit_len", acc, 868);
            check("def_bit_tick", int'(bit_tick), 1);
         end
         if (k == 24) check("sample_after_bit", int'(sample_tick), 1);
      end
      check("two_bits_len", acc, 1736);

      // mid-period load of 10: current period keeps its 54 length
      repeat (5) @(negedge clk);
      load(10, 0);
      wait_tick(100, n);
      check("load10_tail", n, 48);
      for (int k = 0; k < 3; k++) begin
         wait_tick(100, n);
         check("load10_period", n, 10);
      end

      // clamped divisors 0 and 1 give 2-cycle periods
      load(0, 0);
      wait_tick(100, n);
      check("load0_tail", n, 9);
      nbit = 0; nsmp = 0;
      for (int k = 0; k < 16; k++) begin
         wait_tick(100, n);
         if (k < 3) check("clamp0_period", n, 2);
         nbit += int'(bit_tick);
         nsmp += int'(sample_tick);
      end
      check("clamp0_bits_per_16", nbit, 1);
      check("clamp0_samples_per_16", nsmp, 1);
      load(1, 0);
      wait_tick(10, n);
      wait_tick(10, n);
      check("clamp1_period", n, 2);

      // restart coinciding with a terminal count must suppress the tick
      restart = 1'b1; @(negedge clk); restart = 1'b0; @(negedge clk);
      restart = 1'b1; @(negedge clk); restart = 1'b0;
      check("restart_vs_term_tick", int'(os_tick), 0);
      check("restart_vs_term_phase", int'(os_phase), 0);

      // load together with restart applies immediately
      div_int = 16'd54; div_frac = 4'd4; div_load = 1'b1; restart = 1'b1;
      @(negedge clk);
      div_load = 1'b0; restart = 1'b0;
      for (int k = 0; k < 5; k++) wait_tick(100, n);
      check("pre_restart_phase", int'(os_phase), 5);
      repeat (20) @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check("restart_no_tick", int'(os_tick), 0);
      wait_tick(100, n);
      check("restart_first_period", n, 54);
      check("restart_first_phase", int'(os_phase), 1);
      for (int k = 0; k < 7; k++) wait_tick(100, n);
      check("restart_sample", int'(sample_tick), 1);
      check("restart_sample_phase", int'(os_phase), 8);

      // enable dropped mid-bit
      repeat (10) @(negedge clk);
      clk_ena = 1'b0;
      nbit = 0;
      repeat (12) begin
         @(negedge clk);
         nbit += int'(os_tick) + int'(sample_tick) + int'(bit_tick) + int'(os_phase);
      end
      check("disabled_outputs_zero", nbit, 0);
      clk_ena = 1'b1;
      wait_tick(100, n);
      check("reenable_period", n, 54);
      check("reenable_phase", int'(os_phase), 1);

      // reset mid-count after loading 100
      load(100, 0);
      wait_tick(100, n);
      wait_tick(200, n);
      check("div100_period", n, 100);
      repeat (50) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_phase", int'(os_phase), 0);
      check("async_reset_ticks", int'(os_tick) + int'(sample_tick) + int'(bit_tick), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         wait_tick(100, n);
         check($sformatf("post_reset_period%0d", k), n, (k == 4) ? 55 : 54);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/baudgen_os.md
BAUDGEN_OS -- requirements
Module: baudgen_os

Interface
REQ-001 The module SHALL have parameter DIV_W, default 16, giving the width of the integer divisor.
REQ-002 The module SHALL have parameter FRAC_W, default 4, giving the width of the fractional divisor.
REQ-003 The module SHALL have parameter OS, default 16, giving the oversample ticks per bit; legal values are powers of two, 4 or more.
REQ-004 The module SHALL have parameter DEF_INT, default 54, giving the reset integer divisor (100 MHz / 115200 / 16).
REQ-005 The module SHALL have parameter DEF_FRAC, default 4, giving the reset fractional divisor in 1/2^FRAC_W units.
REQ-006 The module SHALL have port clk, input, 1 bit: system clock.
REQ-007 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The module SHALL have port clk_ena, input, 1 bit: 1 = run; 0 = hold initialised with no ticks.
REQ-009 The module SHALL have port restart, input, 1 bit: synchronous phase realignment, used on start-bit edge detection.
REQ-010 The module SHALL have port div_int, input, DIV_W bits: new integer divisor.
REQ-011 The module SHALL have port div_frac, input, FRAC_W bits: new fractional divisor.
REQ-012 The module SHALL have port div_load, input, 1 bit: one-cycle strobe that captures div_int and div_frac.
REQ-013 The module SHALL have port os_tick, output, 1 bit: one-cycle pulse at every oversample period.
REQ-014 The module SHALL have port sample_tick, output, 1 bit: one-cycle pulse at mid-bit.
REQ-015 The module SHALL have port bit_tick, output, 1 bit: one-cycle pulse at end of bit.
REQ-016 The module SHALL have port os_phase, output, clog2(OS) bits: current oversample index within the bit.

Function
REQ-017 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-018 Active divisor: the module SHALL hold an active divisor pair (A_INT, A_FRAC) and a pending pair plus a pending flag.
REQ-019 Load capture: div_load=1 SHALL capture div_int and div_frac into the pending pair and set the pending flag; a later div_load before the pair is applied SHALL overwrite the pending pair.
REQ-020 Load apply: the pending pair SHALL become active at the next terminal count, or on the next edge if clk_ena=0 or restart=1, and the pending flag SHALL then clear.
REQ-021 Divisor clamp: an applied div_int value below 2 SHALL be clamped to 2.
REQ-022 Period length: each oversample period length SHALL be L = A_INT + C, where C is the carry out of the FRAC_W-bit sum frac_acc + A_FRAC.
REQ-023 Counter: the cycle counter SHALL count 0..L-1; the terminal count is counter == L-1.
REQ-024 Terminal count actions: counter <= 0; frac_acc <= (frac_acc + A_FRAC) mod 2^FRAC_W; os_tick=1 in the following cycle.
REQ-025 Phase: os_phase SHALL increment modulo OS at each terminal count, updating in the same cycle os_tick is high.
REQ-026 sample_tick SHALL be asserted together with os_tick when the new os_phase equals OS/2.
REQ-027 bit_tick SHALL be asserted together with os_tick when the new os_phase equals 0, i.e. on wrap from OS-1.
REQ-028 Bit length: over OS periods the bit length SHALL be OS*A_INT + floor(OS*A_FRAC/2^FRAC_W) cycles, exact when OS is 2^FRAC_W or more.
REQ-029 clk_ena=0: counter, frac_acc and os_phase SHALL be 0 and all ticks 0 on the next edge, and state SHALL be held.
REQ-030 Enable start: with the counter starting at 0, the first os_tick SHALL be high in the cycle after the L-th consecutive edge at which clk_ena=1.
REQ-031 Restart: restart=1 with clk_ena=1 SHALL force counter, frac_acc and os_phase to 0, suppress all ticks on that edge, and start counting from 0 on the next edge.
REQ-032 Simultaneous events: restart SHALL take priority over the terminal count; clk_ena=0 SHALL take priority over restart; div_load together with apply SHALL use the newly captured values.
REQ-033 The counter SHALL be DIV_W+1 bits wide so that L = 2^DIV_W-1+1 does not overflow.

Reset
REQ-034 rst_n=0 SHALL asynchronously set counter=0, frac_acc=0, os_phase=0, os_tick=0, sample_tick=0 and bit_tick=0.
REQ-035 rst_n=0 SHALL asynchronously set A_INT=DEF_INT, A_FRAC=DEF_FRAC and clear the pending flag.
REQ-036 Reset release SHALL be taken synchronously: the first count edge is the first edge with rst_n=1 and clk_ena=1.

Verification
REQ-037 Defaults, clk_ena=1 after reset: os_tick periods SHALL be 54 cycles, except every 4th period is 55; bit_tick spacing SHALL be 868 cycles; sample_tick SHALL fall 8 os_ticks after each bit_tick.
REQ-038 Mid-period load of div_int=10, div_frac=0: the current period SHALL complete at its old length and all subsequent periods SHALL be exactly 10 cycles.
REQ-039 Loads of div_int=0 and div_int=1 with div_frac=0: the os_tick period SHALL be 2 cycles and os_phase SHALL cycle 0..15.
REQ-040 restart pulsed at os_phase 5, counter 20: no tick on that edge; next os_tick SHALL follow 54 cycles later with os_phase=1, then sample_tick at os_phase 8.
REQ-041 clk_ena dropped mid-bit then raised: all outputs SHALL be 0 while low; the first os_tick SHALL come 54 cycles after re-enable with os_phase=1.
REQ-042 rst_n asserted mid-count after loading div_int=100: outputs SHALL clear immediately and the period SHALL return to 54/55 after release.
